serial_pair_transmitter_msb_first: RTL and testbench
====================================================

// Module: serial_pair_transmitter_msb_first
// PURPOSE
//  Serialises two parallel W-bit operands (a_word, b_word) into lock-step bit streams, MSB first.
//  Drives serial comparators and other bit-serial consumers.
//  Parallel valid/ready handshake on the input side; serial valid/ready handshake with frame markers on the output side.
//  Sits between a parallel producer and a bit-serial datapath.
// PARAMETERS
//  W  4  operand width in bits, W >= 1
// PORTS
//  clk        in   1  clock, all state updates on posedge
//  rst        in   1  reset, asynchronous, active-high
//  in_valid   in   1  a_word/b_word hold a pair to send
//  in_ready   out  1  block accepts a pair this cycle
//  a_word     in   W  operand A, parallel
//  b_word     in   W  operand B, parallel
//  out_valid  out  1  out_a/out_b hold a valid bit pair
//  out_ready  in   1  consumer takes the current bit pair this cycle
//  out_a      out  1  current bit of A
//  out_b      out  1  current bit of B
//  out_first  out  1  current bit is bit W-1, the first of the frame
//  out_last   out  1  current bit is the last of the frame
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, out_valid=0, out_a=out_b=out_first=out_last=0, count=0.
//    A frame in progress is dropped. No bit of it appears after reset is released.
//  - State machine: two states, IDLE and SHIFT. All outputs except in_ready come straight from registers.
//  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is combinational and gives zero-bubble back-to-back frames.
//  - Accept: in_valid & in_ready.
//    The block loads the shift registers and sets count=W-1.
//    The next cycle has out_valid=1, out_first=1, and out_a/out_b = a_word[W-1]/b_word[W-1].
//    Latency from accept to first bit: 1 cycle.
//  - Shift: out_valid & out_ready & ~out_last.
//    The block advances one bit toward the LSB and decrements count. out_first drops to 0.
//  - out_last = (count==0). With W=1, out_first and out_last are both 1 on the single bit.
//  - Stall: out_valid & ~out_ready holds every output stable; no bit is skipped or repeated.
//  - End of frame: out_valid & out_ready & out_last.
//    If in_valid is also high, the next pair loads in the same cycle, state stays SHIFT, and the following cycle carries its MSB with out_first=1.
//    Otherwise state goes to IDLE and out_valid goes to 0.
//  - a_word/b_word are sampled only on accept. Changes at any other time have no effect.
//  - Counter width is max(1, $clog2(W)). count never wraps below 0.
// CONFIGURATION
//  SERIAL_PAIR_TX_RELATION_EN defined:
//    - Adds outputs rel_less, rel_eq, rel_greater (1 bit each).
//    - Values are registered at accept from a_word vs b_word, unsigned.
//    - They are held stable for the whole frame and reset to 0/1/0.
//    - The bench uses them as the expected result of the downstream comparator.
//  Undefined: these ports and their logic are absent.
// STRUCTURE
//  - Package serial_pkg:
//    - state enum typedef {IDLE, SHIFT}
//    - function cnt_w(W) returning max(1, $clog2(W))
//  - Sub-module serial_word_shifter:
//    - W-bit load/shift-left register with outputs msb and load/shift enables
//    - instantiated twice, once for A and once for B
//  - The FSM, counter and handshake logic live in the top module.
// TESTING
//  1. W=4, a=4'b1010, b=4'b0110, out_ready=1.
//     Bits on out_a/out_b: 1/0, 0/1, 1/1, 0/0. out_first on bit 1, out_last on bit 4. in_ready=1 again in the last cycle.
//  2. Two pairs with in_valid held high: (4'hF, 4'h0) then (4'h3, 4'h3).
//     8 consecutive valid bits, no gap. out_first is asserted in cycles 1 and 5.
//  3. out_ready=0 for 3 cycles after bit 2 of a=4'b1100, b=4'b1011.
//     out_a=1, out_b=0 held for all 3 cycles. Remaining bits arrive in order once out_ready=1.
//  4. rst asserted asynchronously in mid-frame, between clock edges, after bit 2.
//     out_valid=0 before the next edge. After release, IDLE with in_ready=1 and no stale bits.
//  5. W=1, a=1, b=0.
//     A single bit with out_first=out_last=1, out_a=1, out_b=0.
//  6. With SERIAL_PAIR_TX_RELATION_EN defined: a=4'h5, b=4'h9.
//     rel_less=1 for all 4 bit cycles. Feeding the bits to the MSB-first serial comparator ends in a_less_b=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the MSB-first serial pair transmitter.
package serial_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    // Counter width: max(1, clog2(w)).
    function automatic int unsigned cnt_w(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// W-bit parallel-load register that shifts toward the MSB and exposes its top bit.
module serial_word_shifter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/serial_pair_transmitter_msb_first.sv
// Serialises two W-bit operands MSB first with valid/ready on both sides.
// Optional relation flags are enabled with SERIAL_PAIR_TX_RELATION_EN.
module serial_pair_transmitter_msb_first
    import serial_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_word,
    input  logic [W-1:0] b_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_a,
    output logic         out_b,
    output logic         out_first,
    output logic         out_last
`ifdef SERIAL_PAIR_TX_RELATION_EN
    ,
    output logic         rel_less,
    output logic         rel_eq,
    output logic         rel_greater
`endif
);

    localparam int unsigned CW = cnt_w(W);

    state_t        state;
    logic [CW-1:0] count;
    logic          accept;
    logic          shift;
    logic          done;

    assign done     = out_valid & out_ready & out_last;
    assign shift    = out_valid & out_ready & ~out_last;
    assign in_ready = (state == IDLE) | done;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            count     <= CW'(W - 1);
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= (W == 1);
        end else if (shift) begin
            count     <= count - CW'(1);
            out_first <= 1'b0;
            out_last  <= (count == CW'(1));
        end else if (done) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    serial_word_shifter #(.W(W)) u_shift_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .d     (a_word),
        .msb   (out_a)
    );

    serial_word_shifter #(.W(W)) u_shift_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .d     (b_word),
        .msb   (out_b)
    );

`ifdef SERIAL_PAIR_TX_RELATION_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_less    <= 1'b0;
            rel_eq      <= 1'b1;
            rel_greater <= 1'b0;
        end else if (accept) begin
            rel_less    <= a_word < b_word;
            rel_eq      <= a_word == b_word;
            rel_greater <= a_word > b_word;
        end
    end
`endif

endmodule

// File: tb/tb_serial_pair_transmitter_msb_first.sv
// Bench for serial_pair_transmitter_msb_first: frame-level bit queue model, W=4 and W=1 instances.
module tb_serial_pair_transmitter_msb_first;

    localparam int W = 4;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } bit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a_word, b_word;
    logic         out_a, out_b, out_first, out_last;
    logic         in_valid_w1, in_ready_w1, out_valid_w1, out_ready_w1;
    logic [0:0]   a_w1, b_w1;
    logic         out_a_w1, out_b_w1, out_first_w1, out_last_w1;
`ifdef SERIAL_PAIR_TX_RELATION_EN
    logic         rel_less, rel_eq, rel_greater;
    logic         rel_less_w1, rel_eq_w1, rel_greater_w1;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    bit_t exp_q[$];
    bit_t got_q[$];
    int   exp_n, got_n, pend_before;
    bit_t obs_bit;
    logic obs_valid, obs_in_ready, obs_xfer, obs_acc;

    always #5 clk = ~clk;

    serial_pair_transmitter_msb_first #(.W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef SERIAL_PAIR_TX_RELATION_EN
        ,
        .rel_less    (rel_less),
        .rel_eq      (rel_eq),
        .rel_greater (rel_greater)
`endif
    );

    serial_pair_transmitter_msb_first #(.W(1)) u_dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_w1),
        .in_ready  (in_ready_w1),
        .a_word    (a_w1),
        .b_word    (b_w1),
        .out_valid (out_valid_w1),
        .out_ready (out_ready_w1),
        .out_a     (out_a_w1),
        .out_b     (out_b_w1),
        .out_first (out_first_w1),
        .out_last  (out_last_w1)
`ifdef SERIAL_PAIR_TX_RELATION_EN
        ,
        .rel_less    (rel_less_w1),
        .rel_eq      (rel_eq_w1),
        .rel_greater (rel_greater_w1)
`endif
    );

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        exp_n = 0;
        got_n = 0;
    endtask

    // One clock: observe at the falling edge, record transfers and accepts, return at posedge+1.
    task automatic step();
        @(negedge clk);
        pend_before  = exp_n - got_n;
        obs_bit      = {out_a, out_b, out_first, out_last};
        obs_valid    = out_valid;
        obs_in_ready = in_ready;
        obs_xfer     = out_valid && out_ready;
        obs_acc      = in_valid && in_ready;
        if (obs_xfer) begin
            got_q.push_back(obs_bit);
            got_n++;
        end
        if (obs_acc) begin
            for (int i = W - 1; i >= 0; i--) begin
                exp_q.push_back({a_word[i], b_word[i], (i == W - 1), (i == 0)});
                exp_n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; a_word = '0; b_word = '0;
        in_valid_w1 = 0; out_ready_w1 = 0; a_w1 = '0; b_w1 = '0;
        #12;
        n_checks++;
        if ({out_valid, out_a, out_b, out_first, out_last} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {out_valid, out_a, out_b, out_first, out_last});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
`ifdef SERIAL_PAIR_TX_RELATION_EN
        n_checks++;
        if ({rel_less, rel_eq, rel_greater} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_rel: got %b required 010", {rel_less, rel_eq, rel_greater});
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
    endtask

    task automatic test_basic();
        clear_model();
        a_word = 4'b1010; b_word = 4'b0110; in_valid = 1; out_ready = 1;
        for (int c = 0; c < 12 && got_n < 4; c++) begin
            step();
            if (obs_acc) in_valid = 0;
            if (obs_xfer && obs_bit.last) begin
                n_checks++;
                if (obs_in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_in_ready_last: got %b required 1", obs_in_ready);
                end
            end
        end
        n_checks++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d bits required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_bit%0d: got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_x, last_x, n_acc;
        clear_model();
        first_x = -1; last_x = -1; n_acc = 0;
        a_word = 4'hF; b_word = 4'h0; in_valid = 1; out_ready = 1;
        for (int c = 0; c < 20 && got_n < 8; c++) begin
            step();
            if (obs_acc) begin
                n_acc++;
                a_word = 4'h3; b_word = 4'h3;
                if (n_acc == 2) in_valid = 0;
            end
            if (obs_xfer) begin
                if (first_x < 0) first_x = c;
                last_x = c;
            end
        end
        n_checks++;
        if (got_n != 8 || last_x - first_x != 7) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got %0d bits over %0d cycles required 8 over 8",
                     got_n, last_x - first_x + 1);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        clear_model();
        a_word = 4'b1100; b_word = 4'b1011; in_valid = 1; out_ready = 1;
        for (int c = 0; c < 6 && got_n < 1; c++) begin
            step();
            if (obs_acc) in_valid = 0;
        end
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            a_word = 4'($urandom); b_word = 4'($urandom);
            step();
            n_checks++;
            if ({out_valid, out_a, out_b} !== 3'b110) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v/a/b %b required 110", c,
                         {out_valid, out_a, out_b});
            end
        end
        out_ready = 1;
        for (int c = 0; c < 10 && got_n < 4; c++) step();
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d bits required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_bit%0d: got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_model();
        a_word = 4'b1111; b_word = 4'b1111; in_valid = 1; out_ready = 1;
        for (int c = 0; c < 6 && got_n < 2; c++) begin
            step();
            if (obs_acc) in_valid = 0;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_valid: got %b required 0", out_valid);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL async_reset_idle: got ready/valid %b required 10", {in_ready, out_valid});
        end
        clear_model();
        for (int c = 0; c < 6; c++) step();
        n_checks++;
        if (got_n != 0) begin
            n_fail++;
            $display("FAIL async_reset_stale: got %0d bits required 0", got_n);
        end
    endtask

    task automatic test_random();
        bit_t prev_bit;
        logic prev_stall;
        clear_model();
        prev_stall = 0; prev_bit = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = c < 380 ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = ($urandom_range(0, 9) < 7) || c >= 380;
            a_word    = 4'($urandom);
            b_word    = 4'($urandom);
            step();
            n_checks++;
            if (obs_valid !== (pend_before != 0)) begin
                n_fail++;
                $display("FAIL rand_valid c%0d: got %b required %b", c, obs_valid,
                         pend_before != 0);
            end
            n_checks++;
            if (obs_in_ready !== ((pend_before == 0) || (out_ready && pend_before == 1))) begin
                n_fail++;
                $display("FAIL rand_in_ready c%0d: got %b pend %0d out_ready %b", c,
                         obs_in_ready, pend_before, out_ready);
            end
            if (prev_stall) begin
                n_checks++;
                if (obs_bit !== prev_bit) begin
                    n_fail++;
                    $display("FAIL rand_stall_stable c%0d: got %b required %b", c, obs_bit,
                             prev_bit);
                end
            end
            prev_stall = obs_valid && !out_ready;
            prev_bit   = obs_bit;
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d bits required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_bit%0d: got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_w1();
        logic [1:0] pairs[2];
        pairs[0] = 2'b10;
        pairs[1] = 2'b01;
        out_ready_w1 = 1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (in_ready_w1 !== 1'b1) begin
                n_fail++;
                $display("FAIL w1_idle_ready%0d: got %b required 1", k, in_ready_w1);
            end
            {a_w1, b_w1} = pairs[k];
            in_valid_w1 = 1;
            @(posedge clk);
            #1;
            in_valid_w1 = 0;
            n_checks++;
            if ({out_valid_w1, out_first_w1, out_last_w1, out_a_w1, out_b_w1, in_ready_w1} !==
                {3'b111, pairs[k], 1'b1}) begin
                n_fail++;
                $display("FAIL w1_bit%0d: got v/f/l/a/b/rdy %b required %b", k,
                         {out_valid_w1, out_first_w1, out_last_w1, out_a_w1, out_b_w1,
                          in_ready_w1}, {3'b111, pairs[k], 1'b1});
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid_w1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_end%0d: got valid %b required 0", k, out_valid_w1);
            end
        end
    endtask

`ifdef SERIAL_PAIR_TX_RELATION_EN
    task automatic test_relation();
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        logic lt, gt;
        av[0] = 4'h5; bv[0] = 4'h9;
        av[1] = 4'($urandom); bv[1] = 4'($urandom);
        av[2] = 4'h7; bv[2] = 4'h7;
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            clear_model();
            a_word = av[k]; b_word = bv[k]; in_valid = 1;
            for (int c = 0; c < 10 && got_n < W; c++) begin
                step();
                if (obs_acc) in_valid = 0;
                if (out_valid) begin
                    n_checks++;
                    if ({rel_less, rel_eq, rel_greater} !==
                        {av[k] < bv[k], av[k] == bv[k], av[k] > bv[k]}) begin
                        n_fail++;
                        $display("FAIL rel_flags%0d c%0d: got %b", k, c,
                                 {rel_less, rel_eq, rel_greater});
                    end
                end
            end
            // Downstream MSB-first comparator: the first differing bit decides.
            lt = 0; gt = 0;
            foreach (got_q[i]) begin
                if (!lt && !gt && got_q[i].a != got_q[i].b) begin
                    lt = got_q[i].b;
                    gt = got_q[i].a;
                end
            end
            n_checks++;
            if ({lt, gt} !== {av[k] < bv[k], av[k] > bv[k]} || got_n != W) begin
                n_fail++;
                $display("FAIL rel_serial_cmp%0d: got lt/gt %b over %0d bits a=%h b=%h", k,
                         {lt, gt}, got_n, av[k], bv[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_random();
        test_w1();
`ifdef SERIAL_PAIR_TX_RELATION_EN
        test_relation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
